// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a small byte FIFO and a one-byte-at-a-time strobe interface.
// Line errors surface as status (ferr pulse, sticky overrun) and are never delivered as data.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level on rxs
// START  | timing to the middle of the start bit to reject glitches
// DATA   | sampling 8 data bits LSB first at mid-bit
// STOPB  | sampling the stop bit; high pushes the byte, low flags a framing error
// BREAK  | line held low after a framing error, waiting for it to return high
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic                  hold,
   input  logic                  clr_err,
   output logic [7:0]            out,
   output logic                  stop,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ferr,
   output logic                  overrun
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOPB, S_BREAK} state_t;

   state_t                  state, state_nxt;
   logic [TW-1:0]           tmr, tmr_nxt;
   logic [2:0]              bit_idx, bit_nxt;
   logic [7:0]              shreg, shreg_nxt;
   logic                    rx_meta, rxs;
   logic                    push, push_ok, pop, ferr_nxt;
   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [7:0]              mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         state   <= S_IDLE;
         tmr     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         ferr    <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         bit_idx <= bit_nxt;
         shreg   <= shreg_nxt;
         ferr    <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      push      = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         S_IDLE:
            if (!rxs) begin
               state_nxt = S_START;
               tmr_nxt   = T_HALF;
            end
         S_START:
            if (tmr == '0) begin
               if (rxs) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_DATA;
                  tmr_nxt   = T_FULL;
                  bit_nxt   = 3'd0;
               end
            end else begin
               tmr_nxt = tmr - T_ONE;
            end
         S_DATA:
            if (tmr == '0) begin
               shreg_nxt = {rxs, shreg[7:1]};
               tmr_nxt   = T_FULL;
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = S_STOPB;
            end else begin
               tmr_nxt = tmr - T_ONE;
            end
         S_STOPB:
            if (tmr == '0) begin
               if (rxs) begin
                  push      = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_BREAK;
               end
            end else begin
               tmr_nxt = tmr - T_ONE;
            end
         S_BREAK:
            if (rxs) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop     = (count != '0) && !hold && !stop;
   assign push_ok = push && (!count[DEPTH_LOG2] || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         out     <= '0;
         stop    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         stop <= pop;
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            out    <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (clr_err)
            overrun <= 1'b0;
         else if (push && !push_ok)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized bursts
// compared against a queue model of which bytes should survive the FIFO.
module tb_uart_rx_fifo;

   localparam int CPB = 8;
   localparam int DL2 = 2;
   localparam int DEPTH = 1 << DL2;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic        hold;
   logic        clr_err;
   logic [7:0]  out;
   logic        stop;
   logic [DL2:0] count;
   logic        ferr;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ferr_cnt = 0;
   logic [7:0] got[$];
   int         stop_cyc[$];

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
      .clk(clk), .reset(reset), .rx(rx), .hold(hold), .clr_err(clr_err),
      .out(out), .stop(stop), .count(count), .ferr(ferr), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every delivered byte and framing-error pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         if (stop) begin
            got.push_back(out);
            stop_cyc.push_back(cyc);
         end
         if (ferr) ferr_cnt = ferr_cnt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopv, input int extra_low);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = stopv;
      tick(CPB);
      if (extra_low > 0) begin
         rx = 1'b0;
         tick(extra_low);
      end
      rx = 1'b1;
   endtask

   task automatic clear_log();
      got.delete();
      stop_cyc.delete();
      ferr_cnt = 0;
   endtask

   task automatic test_reset();
      n_cmp++; if (out !== 8'h00)   begin n_bad++; $display("FAIL reset_out got %h exp 00", out); end
      n_cmp++; if (stop !== 1'b0)   begin n_bad++; $display("FAIL reset_stop got %b exp 0", stop); end
      n_cmp++; if (count !== '0)    begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
      n_cmp++; if (ferr !== 1'b0)   begin n_bad++; $display("FAIL reset_ferr got %b exp 0", ferr); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_single();
      clear_log();
      hold = 1'b0;
      send_frame(8'h41, 1'b1, 0);
      tick(6);
      n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL single_n got %0d exp 1", got.size()); end
      else begin
         n_cmp++; if (got[0] !== 8'h41) begin n_bad++; $display("FAIL single_byte got %h exp 41", got[0]); end
      end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL single_count got %0d exp 0", count); end
      n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL single_ferr got %0d exp 0", ferr_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h0D;
      clear_log();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_frame(exp_b[i], 1'b1, 0);
         tick(2);
      end
      tick(4);
      n_cmp++; if (count !== 3) begin n_bad++; $display("FAIL b2b_count got %0d exp 3", count); end
      n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL b2b_held got %0d strobes exp 0", got.size()); end
      hold = 1'b0;
      tick(10);
      n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL b2b_n got %0d exp 3", got.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got[i] !== exp_b[i]) begin n_bad++; $display("FAIL b2b_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (stop_cyc[i] - stop_cyc[0] !== 2 * i) begin
               n_bad++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, stop_cyc[i] - stop_cyc[0], 2 * i);
            end
         end
      end
   endtask

   task automatic test_overrun();
      clear_log();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_frame(8'h10 + 8'(i), 1'b1, 0);
         tick(2);
      end
      tick(4);
      n_cmp++; if (count !== 4) begin n_bad++; $display("FAIL ovr_count got %0d exp 4", count); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b exp 1", overrun); end
      hold = 1'b0;
      tick(14);
      n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL ovr_n got %0d exp 4", got.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL ovr_byte%0d got %h exp %h", i, got[i], 8'h10 + 8'(i)); end
         end
      end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      tick(1);
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %b exp 0", overrun); end
   endtask

   task automatic test_framing();
      clear_log();
      hold = 1'b0;
      send_frame(8'h55, 1'b0, 0);
      tick(6);
      n_cmp++; if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_pulse got %0d exp 1", ferr_cnt); end
      n_cmp++; if (got.size() !== 0 || count !== '0) begin
         n_bad++; $display("FAIL ferr_nopush got %0d delivered count %0d exp 0", got.size(), count);
      end
      clear_log();
      send_frame(8'h55, 1'b0, 40);
      tick(6);
      n_cmp++; if (ferr_cnt !== 1) begin n_bad++; $display("FAIL break_ferr got %0d exp 1", ferr_cnt); end
      n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL break_nopush got %0d exp 0", got.size()); end
      clear_log();
      send_frame(8'h7E, 1'b1, 0);
      tick(6);
      n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL after_break_n got %0d exp 1", got.size()); end
      else begin
         n_cmp++; if (got[0] !== 8'h7E) begin n_bad++; $display("FAIL after_break_byte got %h exp 7e", got[0]); end
      end
   endtask

   task automatic test_glitch();
      clear_log();
      hold = 1'b0;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(20);
      n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt); end
      n_cmp++; if (count !== '0 || got.size() !== 0) begin
         n_bad++; $display("FAIL glitch_count got count %0d delivered %0d exp 0", count, got.size());
      end
      send_frame(8'h5A, 1'b1, 0);
      tick(6);
      n_cmp++; if (got.size() !== 1 || got[0] !== 8'h5A) begin
         n_bad++; $display("FAIL glitch_recover got %0d bytes first %h exp 1 byte 5a", got.size(), got.size() > 0 ? got[0] : 8'h00);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'hAA;
      clear_log();
      hold = 1'b1;
      send_frame(8'h33, 1'b1, 0);
      tick(4);
      n_cmp++; if (count !== 1) begin n_bad++; $display("FAIL rstmid_pre_count got %0d exp 1", count); end
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = d[4];
      tick(3);
      reset = 1'b0;
      tick(1);
      n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL rstmid_out got %h exp 00", out); end
      n_cmp++; if (stop !== 1'b0 || ferr !== 1'b0 || overrun !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_flags got stop %b ferr %b overrun %b exp 0", stop, ferr, overrun);
      end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rstmid_count got %0d exp 0", count); end
      rx = 1'b1;
      reset = 1'b1;
      hold = 1'b0;
      tick(4 * CPB);
      clear_log();
      send_frame(8'h0F, 1'b1, 0);
      tick(6);
      n_cmp++; if (got.size() !== 1 || got[0] !== 8'h0F) begin
         n_bad++; $display("FAIL rstmid_next got %0d bytes first %h exp 1 byte 0f", got.size(), got.size() > 0 ? got[0] : 8'h00);
      end
   endtask

   // Bursts under hold: the model keeps the first DEPTH bytes and flags overrun beyond that.
   task automatic test_random();
      logic [7:0] sent[$];
      int n, keep;
      for (int r = 0; r < 4; r++) begin
         clear_log();
         sent.delete();
         n = $urandom_range(1, 6);
         keep = (n > DEPTH) ? DEPTH : n;
         hold = 1'b1;
         for (int i = 0; i < n; i++) begin
            sent.push_back(8'($urandom_range(0, 255)));
            send_frame(sent[i], 1'b1, 0);
            tick($urandom_range(0, 5));
         end
         tick(4);
         n_cmp++; if (count !== keep) begin n_bad++; $display("FAIL rnd%0d_count got %0d exp %0d", r, count, keep); end
         n_cmp++; if (overrun !== (n > DEPTH)) begin n_bad++; $display("FAIL rnd%0d_overrun got %b exp %b", r, overrun, n > DEPTH); end
         hold = 1'b0;
         tick(2 * DEPTH + 6);
         n_cmp++; if (got.size() !== keep) begin n_bad++; $display("FAIL rnd%0d_n got %0d exp %0d", r, got.size(), keep); end
         else begin
            for (int i = 0; i < keep; i++) begin
               n_cmp++;
               if (got[i] !== sent[i]) begin n_bad++; $display("FAIL rnd%0d_byte%0d got %h exp %h", r, i, got[i], sent[i]); end
            end
         end
         clr_err = 1'b1;
         tick(1);
         clr_err = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b0;
      rx = 1'b1;
      hold = 1'b0;
      clr_err = 1'b0;
      tick(3);
      test_reset();
      reset = 1'b1;
      tick(4);
      test_single();
      test_back_to_back();
      test_overrun();
      test_framing();
      test_glitch();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
